// File: rtl/param_bic_if.sv
// param_bic_if: control/status bundle for the parametrised binary counter.
//   master : drives en, clr, load, load_val, up_dn; observes count, tc, ovf
//   slave  : the counter side (inputs and outputs mirrored)
// WIDTH must match the WIDTH of the param_bic instance it connects to.
interface param_bic_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             up_dn;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  modport master (
    output en, clr, load, load_val, up_dn,
    input  count, tc, ovf
  );

  modport slave (
    input  en, clr, load, load_val, up_dn,
    output count, tc, ovf
  );
endinterface

// File: rtl/param_bic.sv
// param_bic: parametrised up/down binary counter with prescaler.
//   clk          system clock, rising-edge
//   rst          asynchronous active-low reset
//   bus (slave)  en       count enable (low holds count and prescaler)
//                clr      synchronous clear of count, prescaler, ovf
//                load     synchronous load of min(load_val, MAX_COUNT)
//                load_val value to load
//                up_dn    1 = up, 0 = down
//                count    registered count
//                tc       registered one-cycle boundary pulse
//                ovf      registered sticky boundary flag
// Parameters: WIDTH, MAX_COUNT (1..2^WIDTH-1), SATURATE (0 wrap / 1 hold),
//             PRESCALE (enabled cycles per step, >= 1).
module param_bic #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 15,
  parameter int SATURATE  = 0,
  parameter int PRESCALE  = 1
) (
  input  logic  clk,
  input  logic  rst,
  param_bic_if.slave bus
);

  // Prescaler needs at least one bit even when PRESCALE=1 (it then stays 0).
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MAX_COUNT);
  localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    ps_q, ps_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;

  always_comb begin
    cnt_d = cnt_q;
    ps_d  = ps_q;
    ovf_d = ovf_q;
    tc_d  = 1'b0;
    step  = 1'b0;

    if (bus.clr) begin
      cnt_d = '0;
      ps_d  = '0;
      ovf_d = 1'b0;
    end else if (bus.load) begin
      cnt_d = (bus.load_val > MAXV) ? MAXV : bus.load_val;
      ps_d  = '0;
    end else if (bus.en) begin
      if (ps_q == PS_LAST) begin
        ps_d = '0;
        step = 1'b1;
      end else begin
        ps_d = ps_q + PW'(1);
      end
    end

    if (step) begin
      if (bus.up_dn) begin
        if (cnt_q == MAXV) begin
          cnt_d = (SATURATE != 0) ? MAXV : '0;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          // Saturating mode re-reports the boundary on every attempted step.
          cnt_d = (SATURATE != 0) ? '0 : MAXV;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      ps_q  <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ps_q  <= ps_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.count = cnt_q;
  assign bus.tc    = tc_q;
  assign bus.ovf   = ovf_q;

endmodule
